// File: rtl/tin_acc_pipe.sv
// tin_acc_pipe: pipelined TIN-lane signed adder tree with multi-beat accumulation.
// Each beat is reduced to one sum and accumulated per first/last-framed group.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   i_vld / i_rdy   input beat handshake (i_rdy is the global advance)
//   i_dat           TIN signed lanes, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_mask          per-lane enable; a masked lane contributes zero
//   i_first/i_last  group framing for the beat
//   o_vld / o_rdy   result handshake
//   o_dat           signed group sum, ACC_WIDTH bits
//   o_ovf           group wrapped (SAT=0) or clamped (SAT=1)
module tin_acc_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int TIN        = 8,
    parameter int LOG2_TIN   = 3,
    parameter int ACC_WIDTH  = DATA_WIDTH + LOG2_TIN + 8,
    parameter bit SAT        = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_vld,
    output logic                       i_rdy,
    input  logic [DATA_WIDTH*TIN-1:0]  i_dat,
    input  logic [TIN-1:0]             i_mask,
    input  logic                       i_first,
    input  logic                       i_last,
    output logic                       o_vld,
    input  logic                       o_rdy,
    output logic [ACC_WIDTH-1:0]       o_dat,
    output logic                       o_ovf
);

    localparam int TW = DATA_WIDTH + LOG2_TIN;
    localparam int XW = ACC_WIDTH + 1;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX =
        {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN =
        {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // A held result blocks the whole pipe; nothing moves until it drains.
    logic advance;
    assign advance = !(o_vld && !o_rdy);
    assign i_rdy   = advance;

    // Level 0 registers the masked lanes; level l holds TIN>>l sums,
    // each one bit wider than the level feeding it.
    genvar l;
    generate
        for (l = 0; l < LOG2_TIN; l++) begin : g_lvl
            localparam int N = TIN >> l;
            localparam int W = DATA_WIDTH + l;

            logic signed [W-1:0] sum [N];
            logic                vld;
            logic                first;
            logic                last;

            if (l == 0) begin : g_in
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        for (int i = 0; i < N; i++) begin
                            sum[i] <= '0;
                        end
                        vld   <= 1'b0;
                        first <= 1'b0;
                        last  <= 1'b0;
                    end else if (advance) begin
                        for (int i = 0; i < N; i++) begin
                            sum[i] <= i_mask[i]
                                ? $signed(i_dat[i*DATA_WIDTH +: DATA_WIDTH])
                                : '0;
                        end
                        vld   <= i_vld;
                        first <= i_first;
                        last  <= i_last;
                    end
                end
            end else begin : g_add
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        for (int i = 0; i < N; i++) begin
                            sum[i] <= '0;
                        end
                        vld   <= 1'b0;
                        first <= 1'b0;
                        last  <= 1'b0;
                    end else if (advance) begin
                        for (int i = 0; i < N; i++) begin
                            sum[i] <= W'(g_lvl[l-1].sum[2*i])
                                    + W'(g_lvl[l-1].sum[2*i+1]);
                        end
                        vld   <= g_lvl[l-1].vld;
                        first <= g_lvl[l-1].first;
                        last  <= g_lvl[l-1].last;
                    end
                end
            end
        end
    endgenerate

    // The final pair is added combinationally into the accumulate stage.
    logic signed [TW-1:0] tree_sum;
    logic                 t_vld;
    logic                 t_first;
    logic                 t_last;

    assign tree_sum = TW'(g_lvl[LOG2_TIN-1].sum[0])
                    + TW'(g_lvl[LOG2_TIN-1].sum[1]);
    assign t_vld    = g_lvl[LOG2_TIN-1].vld;
    assign t_first  = g_lvl[LOG2_TIN-1].first;
    assign t_last   = g_lvl[LOG2_TIN-1].last;

    logic signed [ACC_WIDTH-1:0] acc;
    logic                        sticky;
    logic signed [XW-1:0]        s_ext;
    logic signed [XW-1:0]        nxt;
    logic                        oor;
    logic signed [ACC_WIDTH-1:0] res;
    logic                        sticky_nxt;

    // One guard bit is enough: two in-range values never overflow XW.
    always_comb begin
        s_ext      = XW'(tree_sum);
        nxt        = t_first ? s_ext : XW'(acc) + s_ext;
        oor        = nxt[XW-1] != nxt[XW-2];
        res        = nxt[ACC_WIDTH-1:0];
        if (oor && SAT) begin
            res = nxt[XW-1] ? ACC_MIN : ACC_MAX;
        end
        sticky_nxt = (t_first ? 1'b0 : sticky) | oor;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            sticky <= 1'b0;
            o_vld  <= 1'b0;
            o_dat  <= '0;
            o_ovf  <= 1'b0;
        end else if (advance) begin
            if (t_vld) begin
                acc    <= res;
                sticky <= sticky_nxt;
            end
            if (t_vld && t_last) begin
                o_dat <= res;
                o_ovf <= sticky_nxt;
                o_vld <= 1'b1;
            end else if (o_rdy) begin
                o_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tin_acc_pipe.sv
// tb_tin_acc_pipe: scoreboard bench for tin_acc_pipe.
// Main DUT uses defaults; two 20-bit accumulator copies cover wrap/saturate.
module tb_tin_acc_pipe;

    localparam int DW  = 16;
    localparam int TIN = 8;
    localparam int LG  = 3;
    localparam int AW  = DW + LG + 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_vld;
    logic              i_first;
    logic              i_last;
    logic              o_rdy;
    logic [DW*TIN-1:0] i_dat;
    logic [TIN-1:0]    i_mask;

    logic              i_rdy;
    logic              o_vld;
    logic              o_ovf;
    logic [AW-1:0]     o_dat;

    logic              st_i_rdy;
    logic              st_o_vld;
    logic              st_o_ovf;
    logic [19:0]       st_o_dat;
    logic              wr_i_rdy;
    logic              wr_o_vld;
    logic              wr_o_ovf;
    logic [19:0]       wr_o_dat;

    always #5 clk = ~clk;

    tin_acc_pipe dut (
        .clk(clk), .rst(rst),
        .i_vld(i_vld), .i_rdy(i_rdy),
        .i_dat(i_dat), .i_mask(i_mask),
        .i_first(i_first), .i_last(i_last),
        .o_vld(o_vld), .o_rdy(o_rdy),
        .o_dat(o_dat), .o_ovf(o_ovf)
    );

    tin_acc_pipe #(.ACC_WIDTH(20), .SAT(1'b1)) dut_sat (
        .clk(clk), .rst(rst),
        .i_vld(i_vld), .i_rdy(st_i_rdy),
        .i_dat(i_dat), .i_mask(i_mask),
        .i_first(i_first), .i_last(i_last),
        .o_vld(st_o_vld), .o_rdy(o_rdy),
        .o_dat(st_o_dat), .o_ovf(st_o_ovf)
    );

    tin_acc_pipe #(.ACC_WIDTH(20), .SAT(1'b0)) dut_wrap (
        .clk(clk), .rst(rst),
        .i_vld(i_vld), .i_rdy(wr_i_rdy),
        .i_dat(i_dat), .i_mask(i_mask),
        .i_first(i_first), .i_last(i_last),
        .o_vld(wr_o_vld), .o_rdy(o_rdy),
        .o_dat(wr_o_dat), .o_ovf(wr_o_ovf)
    );

    typedef struct {
        longint dat;
        bit     ovf;
    } exp_t;

    exp_t   q[$];
    longint m_acc    = 0;
    bit     m_sticky = 1'b0;
    int     checks   = 0;
    int     errors   = 0;
    int     cyc      = 0;

    always @(posedge clk) cyc++;

    // Reference for the main DUT: AW-bit wrapping accumulator.
    function automatic void model_beat(
        input logic [DW*TIN-1:0] d,
        input logic [TIN-1:0]    m,
        input logic              f,
        input logic              l
    );
        longint s;
        longint nxt;
        longint maxv;
        longint minv;
        bit     oor;
        logic [AW-1:0] t;
        s    = 0;
        maxv = (longint'(1) <<< (AW-1)) - 1;
        minv = -(longint'(1) <<< (AW-1));
        for (int k = 0; k < TIN; k++) begin
            if (m[k]) s += longint'($signed(d[k*DW +: DW]));
        end
        nxt = f ? s : m_acc + s;
        oor = (nxt > maxv) || (nxt < minv);
        t   = nxt[AW-1:0];
        m_acc    = longint'($signed(t));
        m_sticky = (f ? 1'b0 : m_sticky) | oor;
        if (l) q.push_back('{m_acc, m_sticky});
    endfunction

    // Every result handed downstream is popped and compared in order.
    always @(negedge clk) begin
        longint got;
        exp_t   e;
        if (!rst && o_vld && o_rdy) begin
            checks++;
            got = $signed(o_dat);
            if (q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra got %0d ovf %0b, none expected",
                         got, o_ovf);
            end else begin
                e = q.pop_front();
                if (got !== e.dat || o_ovf !== e.ovf) begin
                    errors++;
                    $display("FAIL sb_result got %0d/%0b exp %0d/%0b",
                             got, o_ovf, e.dat, e.ovf);
                end
            end
        end
    end

    task automatic send(
        input logic [DW*TIN-1:0] d,
        input logic [TIN-1:0]    m,
        input logic              f,
        input logic              l
    );
        int n;
        n       = 0;
        i_vld   = 1'b1;
        i_dat   = d;
        i_mask  = m;
        i_first = f;
        i_last  = l;
        @(negedge clk);
        while (!i_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!i_rdy) begin
            errors++;
            $display("FAIL send_accept i_rdy %0b after %0d cycles, need 1",
                     i_rdy, n);
        end else begin
            model_beat(d, m, f, l);
        end
        @(posedge clk);
        #1;
        i_vld   = 1'b0;
        i_first = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic wait_drain(output int left);
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        left = q.size();
    endtask

    function automatic logic [DW*TIN-1:0] fill(input logic [DW-1:0] v);
        logic [DW*TIN-1:0] d;
        for (int k = 0; k < TIN; k++) d[k*DW +: DW] = v;
        return d;
    endfunction

    task automatic test_reset();
        rst     = 1'b1;
        i_vld   = 1'b0;
        i_first = 1'b0;
        i_last  = 1'b0;
        i_dat   = '0;
        i_mask  = '0;
        o_rdy   = 1'b1;
        repeat (3) @(negedge clk);
        checks += 4;
        if (o_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_o_vld got %0b exp 0", o_vld);
        end
        if (o_dat !== '0) begin
            errors++;
            $display("FAIL reset_o_dat got %0d exp 0", o_dat);
        end
        if (o_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_o_ovf got %0b exp 0", o_ovf);
        end
        if (i_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_i_rdy got %0b exp 1", i_rdy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_acc    = 0;
        m_sticky = 1'b0;
    endtask

    task automatic test_single();
        logic [DW*TIN-1:0] d;
        longint got;
        int left;
        for (int k = 0; k < TIN; k++) d[k*DW +: DW] = DW'(k + 1);
        send(d, 8'hFF, 1'b1, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (o_vld !== 1'b0) begin
            errors++;
            $display("FAIL single_early o_vld %0b exp 0", o_vld);
        end
        @(posedge clk);
        #1;
        got = $signed(o_dat);
        checks += 3;
        if (o_vld !== 1'b1) begin
            errors++;
            $display("FAIL single_latency o_vld %0b exp 1", o_vld);
        end
        if (got !== 36) begin
            errors++;
            $display("FAIL single_sum got %0d exp 36", got);
        end
        if (o_ovf !== 1'b0) begin
            errors++;
            $display("FAIL single_ovf got %0b exp 0", o_ovf);
        end
        wait_drain(left);
        checks++;
        if (left != 0) begin
            errors++;
            $display("FAIL single_drain pending %0d exp 0", left);
        end
    endtask

    task automatic test_mask();
        logic [DW*TIN-1:0] d;
        longint got;
        int left;
        d = fill(16'hFFFF);
        send(d, 8'h0F, 1'b1, 1'b0);
        send(d, 8'h00, 1'b0, 1'b0);
        send(d, 8'h0F, 1'b0, 1'b0);
        send(d, 8'h0F, 1'b0, 1'b1);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        got = $signed(o_dat);
        checks += 2;
        if (got !== -12) begin
            errors++;
            $display("FAIL mask_sum got %0d exp -12", got);
        end
        if (o_ovf !== 1'b0) begin
            errors++;
            $display("FAIL mask_ovf got %0b exp 0", o_ovf);
        end
        send(d, 8'h00, 1'b1, 1'b1);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        got = $signed(o_dat);
        checks++;
        if (got !== 0) begin
            errors++;
            $display("FAIL mask_zero got %0d exp 0", got);
        end
        wait_drain(left);
        checks++;
        if (left != 0) begin
            errors++;
            $display("FAIL mask_drain pending %0d exp 0", left);
        end
    endtask

    // Per beat 8*32767 = 262136. 20-bit running sums:
    // 262136, 524272, then 786408 leaves range.
    // Saturating clamps there and stays at 524287.
    // Wrapping ends at 1310680 - 2^20 = 262104.
    task automatic test_ovf();
        logic [DW*TIN-1:0] d;
        int left;
        d = fill(16'h7FFF);
        for (int b = 0; b < 5; b++) begin
            send(d, 8'hFF, b == 0, b == 4);
        end
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        checks += 4;
        if (st_o_dat !== 20'd524287) begin
            errors++;
            $display("FAIL ovf_sat_dat got %0d exp 524287", st_o_dat);
        end
        if (st_o_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sat_flag got %0b exp 1", st_o_ovf);
        end
        if (wr_o_dat !== 20'd262104) begin
            errors++;
            $display("FAIL ovf_wrap_dat got %0d exp 262104", wr_o_dat);
        end
        if (wr_o_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_wrap_flag got %0b exp 1", wr_o_ovf);
        end
        wait_drain(left);
        checks++;
        if (left != 0) begin
            errors++;
            $display("FAIL ovf_drain pending %0d exp 0", left);
        end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] hold;
        int n;
        int left;
        o_rdy = 1'b0;
        fork
            begin
                for (int j = 0; j < 6; j++) begin
                    send(fill(DW'(j * 100 + 3)), 8'hFF, 1'b1, 1'b1);
                end
                send(fill(16'd7), 8'hF0, 1'b1, 1'b0);
                send(fill(16'hFFFE), 8'h3C, 1'b0, 1'b1);
            end
            begin
                n = 0;
                while (!o_vld && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                checks++;
                if (!o_vld) begin
                    errors++;
                    $display("FAIL bp_wait o_vld %0b exp 1", o_vld);
                end
                hold = o_dat;
                repeat (6) begin
                    @(negedge clk);
                    checks += 2;
                    if (i_rdy !== 1'b0) begin
                        errors++;
                        $display("FAIL bp_i_rdy got %0b exp 0", i_rdy);
                    end
                    if (o_dat !== hold) begin
                        errors++;
                        $display("FAIL bp_stable got %0d exp %0d",
                                 o_dat, hold);
                    end
                end
                @(posedge clk);
                #1;
                o_rdy = 1'b1;
            end
        join
        wait_drain(left);
        checks++;
        if (left != 0) begin
            errors++;
            $display("FAIL bp_drain pending %0d exp 0", left);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW*TIN-1:0] d;
        int c0;
        int left;
        o_rdy = 1'b1;
        c0 = cyc;
        for (int j = 0; j < 16; j++) begin
            for (int k = 0; k < TIN; k++) begin
                d[k*DW +: DW] = DW'($urandom());
            end
            if (j == 3) d = fill(16'h8000);
            if (j == 4) d = fill(16'h7FFF);
            send(d, TIN'($urandom()) | ((j < 5) ? 8'hFF : 8'h00),
                 1'b1, 1'b1);
        end
        checks++;
        if (cyc - c0 != 16) begin
            errors++;
            $display("FAIL b2b_rate got %0d cycles exp 16", cyc - c0);
        end
        wait_drain(left);
        checks++;
        if (left != 0) begin
            errors++;
            $display("FAIL b2b_drain pending %0d exp 0", left);
        end
    endtask

    task automatic test_reset_mid();
        int left;
        send(fill(16'd50), 8'hFF, 1'b1, 1'b0);
        send(fill(16'd60), 8'hFF, 1'b0, 1'b0);
        rst = 1'b1;
        q.delete();
        m_acc    = 0;
        m_sticky = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (o_vld !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_o_vld got %0b exp 0", o_vld);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(fill(16'd5), 8'hFF, 1'b1, 1'b0);
        send(fill(16'd9), 8'h81, 1'b0, 1'b1);
        wait_drain(left);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (left != 0) begin
            errors++;
            $display("FAIL rstmid_drain pending %0d exp 0", left);
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_single();
        test_mask();
        test_ovf();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
